axi_sram_slave: RTL and testbench
=================================

# axi_sram_slave

AXI3-style single-port-per-channel SRAM responder: the memory end of the CPU's AXI master bridge, used as the behavioural/FPGA main memory behind the core in simulation and board bring-up. It accepts independent read and write bursts, stores data in an internal byte-writable word array, and returns R beats and B responses with echoed IDs. Read and write paths are separate FSMs that share only the storage.

## Interface
- ADDR_W, 16: decoded byte-address bits; storage depth 2^(ADDR_W-2) 32-bit words.
- BASE_ADDR, 32'h0000_0000: window base; only bits [31:ADDR_W] are used, and only by the DECERR feature.
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- arid/awid  in  4  request IDs; araddr/awaddr  in  32  byte addresses.
- arlen/awlen  in  8  beats-1; arsize/awsize  in  3  ignored, beats are always 32-bit; arburst/awburst  in  2  burst type.
- arvalid/awvalid  in  1; arready/awready  out  1.
- rid  out  4; rdata  out  32; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1.
- wid  in  4  ignored; wdata  in  32; wstrb  in  4; wlast  in  1  ignored, beat count from awlen governs; wvalid  in  1; wready  out  1.
- bid  out  4; bresp  out  2; bvalid  out  1; bready  in  1.
- The lock, cache and prot fields are not ported; the instantiating level leaves them unconnected.

## Operation
- Read FSM: R_IDLE (arready=1) -> on arvalid&&arready latch id, addr, len, burst -> R_DATA (rvalid=1). On rvalid&&rready: if beat count equals len, go to R_IDLE; else advance address and load the next word into rdata on the same edge.
- Write FSM: W_IDLE (awready=1) -> on AW handshake latch id, addr, len, burst -> W_DATA (wready=1). Each W handshake writes the bytes enabled by wstrb to mem[addr[ADDR_W-1:2]]. After len+1 beats -> W_RESP (bvalid=1, bid=latched id, bresp=OKAY). On bready -> W_IDLE.
- wvalid before AW: wready stays 0 until AW is accepted (legal stall).
- Address update per beat: FIXED (00) holds the address; INCR (01) adds 4; WRAP (10) and reserved (11) are treated as INCR. araddr[1:0] is ignored for indexing. An address past the top of the array wraps modulo depth.
- rlast=1 only on the final beat. rdata, rid, rresp and rlast stay stable while rvalid && !rready.
- Read/write collision on the same word in one cycle: the read beat loaded that edge returns the old data; the write lands at the edge.
- The storage array has no reset; contents survive aresetn.

## Timing
- Reset values: arready, awready, rvalid, wready, bvalid, rlast = 0; rdata = 0; rid, bid = 0; rresp, bresp = 2'b00. States are R_IDLE and W_IDLE. arready and awready rise on the first clock after aresetn deasserts.
- Read latency: AR handshake at edge T -> first rvalid in cycle T+1. With rready held high, one beat per cycle and no bubbles.
- arready=0 throughout R_DATA; awready=0 throughout W_DATA and W_RESP. There are no outstanding transactions beyond one read and one write.
- Write response: last W handshake at edge T -> bvalid in cycle T+1. Next AW is accepted no earlier than the cycle after the B handshake.
- Reset asserted mid-burst: all valid/ready outputs drop immediately (async), the burst is abandoned, and beats already written remain in memory.

## Configuration
- AXI_SLV_DECERR_EN defined: a request with addr[31:ADDR_W] != BASE_ADDR[31:ADDR_W] (checked at the AR/AW handshake) is flagged for the whole burst. Every read beat returns rresp=2'b11 and rdata=0. W beats are accepted but discarded, and bresp=2'b11.
- Not defined: no decode is performed, high bits are ignored (aliasing), and responses are always OKAY.

## Structure
- Shared package axi_slv_pkg holds: resp codes (OKAY=2'b00, DECERR=2'b11); burst codes (FIXED, INCR, WRAP); read and write state encodings; the 4-bit ID width constant.
- Sub-module axi_slv_ram: word array with asynchronous read port and 4-lane byte-write port. It keeps the two FSMs in the top level free of storage detail.

## Test plan
- Single write then read. AW 0x100 id 3, W 0xDEADBEEF strb 4'hF -> B with bid=3, bresp=0. Then AR 0x100 id 5 -> rvalid at T+1, rdata=0xDEADBEEF, rid=5, rlast=1.
- Byte strobes. Write 0xFFFFFFFF to 0x40, then write 0x11223344 with strb 4'b0101 -> read of 0x40 returns 0xFF22FF44.
- INCR read, arlen=3 from 0x200 (preloaded 1..4), rready toggled every other cycle -> beats 1,2,3,4 with rlast only on beat 4; rdata held stable while rready=0.
- FIXED write, awlen=2 to 0x300 with data A,B,C; bready held low 5 cycles -> mem[0x300]=C; bvalid held 5 cycles; awready=0 until the B handshake.
- Reset mid-read during beat 2 of a 4-beat burst -> rvalid=0 immediately; arready=1 one cycle after release; earlier-written data still readable.
- With AXI_SLV_DECERR_EN, ADDR_W=16, BASE=0, read 0x0001_0000 -> rresp=2'b11, rdata=0. Without the macro, the same read returns mem[0].

Source files
------------

// File: rtl/axi_slv_pkg.sv
// Shared definitions for the AXI SRAM responder: response and burst codes,
// read/write FSM state encodings and the request ID width.
package axi_slv_pkg;

    localparam int ID_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

    // Only FIXED holds the address; WRAP and the reserved code step like INCR.
    function automatic logic is_fixed(input logic [1:0] burst);
        return burst == BURST_FIXED;
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3-style bus between the CPU bridge (master) and the SRAM responder (slave).
// Lock, cache and prot are intentionally absent.
interface axi_sram_slave_if;
    import axi_slv_pkg::*;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        output wid, wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        input  wid, wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready
    );

endinterface

// File: rtl/axi_slv_ram.sv
// Word array with an asynchronous read port and a byte-lane write port.
// No reset: contents survive aresetn. A same-word read in the write cycle
// sees the old data because the write only lands at the clock edge.
module axi_slv_ram #(
    parameter int IDX_W = 14
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      wdata
);

    logic [3:0][7:0] mem [2**IDX_W];

    assign rdata = mem[raddr];

    // Byte-enabled write of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[waddr][i] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI SRAM responder: independent read and write FSMs sharing one word array.
// Optional address decode with DECERR responses is enabled by defining
// AXI_SLV_DECERR_EN; without it high address bits alias into the array.
module axi_sram_slave
    import axi_slv_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           aclk,
    input  logic           aresetn,
    axi_sram_slave_if.slave bus
);

    localparam int IDX_W = ADDR_W - 2;

    function automatic logic [IDX_W-1:0] step(input logic [IDX_W-1:0] idx,
                                              input logic [1:0]       burst);
        return is_fixed(burst) ? idx : idx + {{(IDX_W-1){1'b0}}, 1'b1};
    endfunction

    logic             rst_done;
    logic             ar_err, aw_err;

    rstate_e          r_state, r_next;
    logic [ID_W-1:0]  r_id;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_len, r_cnt;
    logic [1:0]       r_burst;
    logic             r_err;
    logic [31:0]      r_data;
    logic             ar_hs, r_hs, r_last_beat;

    wstate_e          w_state, w_next;
    logic [ID_W-1:0]  b_id;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_len, w_cnt;
    logic [1:0]       w_burst;
    logic             w_err;
    logic             aw_hs, w_hs, w_last_beat;

    logic [IDX_W-1:0] ram_raddr;
    logic [31:0]      ram_rdata;

`ifdef AXI_SLV_DECERR_EN
    assign ar_err = bus.araddr[31:ADDR_W] != BASE_ADDR[31:ADDR_W];
    assign aw_err = bus.awaddr[31:ADDR_W] != BASE_ADDR[31:ADDR_W];
`else
    assign ar_err = 1'b0;
    assign aw_err = 1'b0;
`endif

    // Fields the responder deliberately ignores.
    logic unused_bits;
    assign unused_bits = ^{bus.arsize, bus.awsize, bus.wid, bus.wlast,
                           bus.araddr[1:0], bus.awaddr[1:0],
                           bus.araddr[31:ADDR_W], bus.awaddr[31:ADDR_W], BASE_ADDR};

    // Holds the ready outputs low until the first edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_done <= 1'b0;
        else          rst_done <= 1'b1;
    end

    assign ar_hs       = bus.arvalid && bus.arready;
    assign r_hs        = bus.rvalid && bus.rready;
    assign r_last_beat = r_cnt == r_len;

    assign aw_hs       = bus.awvalid && bus.awready;
    assign w_hs        = bus.wvalid && bus.wready;
    assign w_last_beat = w_cnt == w_len;

    // In idle the RAM looks up the incoming address; mid-burst it looks up
    // the next beat so rdata can be reloaded on the accepting edge.
    assign ram_raddr = (r_state == R_IDLE) ? bus.araddr[ADDR_W-1:2] : step(r_idx, r_burst);

    axi_slv_ram #(.IDX_W(IDX_W)) u_ram (
        .clk   (aclk),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .we    (w_hs && !w_err),
        .waddr (w_idx),
        .wstrb (bus.wstrb),
        .wdata (bus.wdata)
    );

    // ---------------- read path ----------------

    // Read state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Read next-state: one burst at a time, leave after the last accepted beat.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read handshake outputs decoded from state.
    always_comb begin
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        case (r_state)
            R_IDLE:  bus.arready = rst_done;
            R_DATA:  begin
                bus.rvalid = 1'b1;
                bus.rlast  = r_last_beat;
            end
            default: ;
        endcase
    end

    // Read datapath: latch the request and register each beat's data.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else if (ar_hs) begin
            r_id    <= bus.arid;
            r_idx   <= bus.araddr[ADDR_W-1:2];
            r_len   <= bus.arlen;
            r_cnt   <= '0;
            r_burst <= bus.arburst;
            r_err   <= ar_err;
            r_data  <= ar_err ? '0 : ram_rdata;
        end else if (r_hs && !r_last_beat) begin
            r_cnt   <= r_cnt + 8'd1;
            r_idx   <= step(r_idx, r_burst);
            r_data  <= r_err ? '0 : ram_rdata;
        end
    end

    assign bus.rid   = r_id;
    assign bus.rdata = r_data;
    assign bus.rresp = r_err ? RESP_DECERR : RESP_OKAY;

    // ---------------- write path ----------------

    // Write state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Write next-state: collect len+1 beats, then hold the response until taken.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP:  if (bus.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write handshake outputs decoded from state.
    always_comb begin
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        case (w_state)
            W_IDLE:  bus.awready = rst_done;
            W_DATA:  bus.wready  = 1'b1;
            W_RESP:  bus.bvalid  = 1'b1;
            default: ;
        endcase
    end

    // Write datapath: latch the request and step the word index per beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            b_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            b_id    <= bus.awid;
            w_idx   <= bus.awaddr[ADDR_W-1:2];
            w_len   <= bus.awlen;
            w_cnt   <= '0;
            w_burst <= bus.awburst;
            w_err   <= aw_err;
        end else if (w_hs && !w_last_beat) begin
            w_cnt   <= w_cnt + 8'd1;
            w_idx   <= step(w_idx, w_burst);
        end
    end

    assign bus.bid   = b_id;
    assign bus.bresp = w_err ? RESP_DECERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave against a word/byte memory model.
// Build with AXI_SLV_DECERR_EN defined to exercise the decode-error variant.
module tb_axi_sram_slave;
    import axi_slv_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 1 << (ADDR_W - 2);
`ifdef AXI_SLV_DECERR_EN
    localparam bit DECODE_ON = 1'b1;
`else
    localparam bit DECODE_ON = 1'b0;
`endif

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    axi_sram_slave_if bus();

    axi_sram_slave #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    logic [31:0] mem_m [DEPTH];
    logic [3:0]  kb    [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [31:0] rb [256];
    logic [1:0]  first_rresp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit dec_err(input logic [31:0] a);
        return DECODE_ON && (a[31:ADDR_W] != '0);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(a[ADDR_W-1:2]);
    endfunction

    function automatic int next_word(input int idx, input logic [1:0] burst);
        return (burst == 2'b00) ? idx : (idx + 1) % DEPTH;
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int bdelay, input bit early, input bit gaps);
        int idx = word_of(addr);
        bit err = dec_err(addr);
        int n;
        if (early) begin
            bus.wvalid = 1'b1; bus.wdata = wd[0]; bus.wstrb = ws[0];
            repeat (2) begin
                @(posedge aclk); #1;
                chk("wready_before_aw", 32'(bus.wready), 32'd0);
            end
        end
        bus.awid = id; bus.awaddr = addr; bus.awlen = len[7:0];
        bus.awburst = burst; bus.awsize = 3'd2; bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 50) begin @(posedge aclk); #1; n++; end
        chk("awready", 32'(bus.awready), 32'd1);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            bus.wvalid = 1'b1; bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = (b == len);
            n = 0;
            while (!bus.wready && n < 50) begin @(posedge aclk); #1; n++; end
            chk("wready", 32'(bus.wready), 32'd1);
            chk("awready_busy_w", 32'(bus.awready), 32'd0);
            @(posedge aclk); #1;
            if (!err) begin
                for (int k = 0; k < 4; k++) begin
                    if (ws[b][k]) begin
                        mem_m[idx][8*k +: 8] = wd[b][8*k +: 8];
                        kb[idx][k] = 1'b1;
                    end
                end
            end
            idx = next_word(idx, burst);
            if (gaps && b < len && $urandom_range(0, 2) == 0) begin
                bus.wvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge aclk);
                #1;
            end
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        chk("bvalid_latency", 32'(bus.bvalid), 32'd1);
        chk("bid", 32'(bus.bid), 32'(id));
        chk("bresp", 32'(bus.bresp), err ? 32'd3 : 32'd0);
        repeat (bdelay) begin
            @(posedge aclk); #1;
            chk("bvalid_hold", 32'(bus.bvalid), 32'd1);
            chk("awready_busy_b", 32'(bus.awready), 32'd0);
        end
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
        chk("bvalid_after_b", 32'(bus.bvalid), 32'd0);
        chk("awready_after_b", 32'(bus.awready), 32'd1);
    endtask

    // mode: 0 rready high, 1 toggle starting low, 2 random
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int mode);
        int idx = word_of(addr);
        bit err = dec_err(addr);
        int n, beat, cyc;
        bit stalled;
        logic [31:0] held;
        bus.arid = id; bus.araddr = addr; bus.arlen = len[7:0];
        bus.arburst = burst; bus.arsize = 3'd2; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin @(posedge aclk); #1; n++; end
        chk("arready", 32'(bus.arready), 32'd1);
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        chk("rvalid_latency", 32'(bus.rvalid), 32'd1);
        beat = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (beat <= len && cyc < 2000) begin
            chk("rvalid", 32'(bus.rvalid), 32'd1);
            chk("arready_busy", 32'(bus.arready), 32'd0);
            if (err) chk("rdata_decerr", bus.rdata, 32'd0);
            else if (kb[idx] == 4'hF) chk("rdata", bus.rdata, mem_m[idx]);
            chk("rid", 32'(bus.rid), 32'(id));
            chk("rresp", 32'(bus.rresp), err ? 32'd3 : 32'd0);
            chk("rlast", 32'(bus.rlast), 32'(beat == len));
            if (stalled) chk("rdata_hold", bus.rdata, held);
            case (mode)
                0:       bus.rready = 1'b1;
                1:       bus.rready = cyc[0];
                default: bus.rready = 1'($urandom_range(0, 1));
            endcase
            if (bus.rready) begin
                rb[beat] = bus.rdata;
                if (beat == 0) first_rresp = bus.rresp;
            end
            held = bus.rdata;
            stalled = !bus.rready;
            @(posedge aclk); #1;
            cyc++;
            if (bus.rready) begin
                beat++;
                idx = next_word(idx, burst);
            end
        end
        bus.rready = 1'b0;
        chk("read_complete", 32'(beat), 32'(len + 1));
        chk("rvalid_after", 32'(bus.rvalid), 32'd0);
        chk("arready_after", 32'(bus.arready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        logic [31:0] a;
        logic [1:0] br;
        for (int i = 0; i < DEPTH; i++) kb[i] = 4'h0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.rready = 1'b0; bus.bready = 1'b0;
        first_rresp = '0;

        // reset values
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_wready", 32'(bus.wready), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rlast", 32'(bus.rlast), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_rid", 32'(bus.rid), 32'd0);
        chk("rst_bid", 32'(bus.bid), 32'd0);
        chk("rst_rresp", 32'(bus.rresp), 32'd0);
        chk("rst_bresp", 32'(bus.bresp), 32'd0);
        #2 aresetn = 1'b1;
        #1 chk("arready_pre_edge", 32'(bus.arready), 32'd0);
        @(posedge aclk); #1;
        chk("arready_first_edge", 32'(bus.arready), 32'd1);
        chk("awready_first_edge", 32'(bus.awready), 32'd1);

        // single write then read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(4'd3, 32'h100, 0, BURST_INCR, 0, 1'b0, 1'b0);
        axi_read(4'd5, 32'h100, 0, BURST_INCR, 0);
        chk("single_rdata", rb[0], 32'hDEADBEEF);

        // byte strobes
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        axi_write(4'd1, 32'h40, 0, BURST_INCR, 0, 1'b0, 1'b0);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        axi_write(4'd2, 32'h40, 0, BURST_INCR, 1, 1'b0, 1'b0);
        axi_read(4'd2, 32'h40, 0, BURST_INCR, 0);
        chk("strobe_rdata", rb[0], 32'hFF22FF44);

        // INCR read with rready toggling
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        axi_write(4'd6, 32'h200, 3, BURST_INCR, 0, 1'b0, 1'b0);
        axi_read(4'd7, 32'h200, 3, BURST_INCR, 1);
        for (int i = 0; i < 4; i++) chk("incr_beat", rb[i], 32'(i + 1));

        // FIXED write with slow bready and early wvalid
        wd[0] = 32'hAAAA0001; wd[1] = 32'hBBBB0002; wd[2] = 32'hCCCC0003;
        ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        axi_write(4'd9, 32'h300, 2, BURST_FIXED, 5, 1'b1, 1'b0);
        axi_read(4'd9, 32'h300, 0, BURST_INCR, 0);
        chk("fixed_last", rb[0], 32'hCCCC0003);

        // INCR wrapping past the top of the array
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h5A00_0000 + 32'(i); ws[i] = 4'hF; end
        axi_write(4'd4, 32'hFFF8, 3, BURST_WRAP, 0, 1'b0, 1'b0);
        axi_read(4'd4, 32'hFFF8, 3, BURST_INCR, 2);
        chk("wrap_word0", rb[2], 32'h5A00_0002);

        // reset during beat 2 of a 4-beat read
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA000_0000 + 32'(i); ws[i] = 4'hF; end
        axi_write(4'd1, 32'h500, 3, BURST_INCR, 0, 1'b0, 1'b0);
        bus.arid = 4'd2; bus.araddr = 32'h500; bus.arlen = 8'd3; bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        @(posedge aclk); #1;
        chk("rst_mid_beat2", bus.rdata, 32'hA000_0001);
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_mid_arready", 32'(bus.arready), 32'd0);
        bus.rready = 1'b0;
        @(posedge aclk); #2;
        aresetn = 1'b1;
        #1 chk("rst_mid_arready_pre", 32'(bus.arready), 32'd0);
        @(posedge aclk); #1;
        chk("rst_mid_arready_post", 32'(bus.arready), 32'd1);
        axi_read(4'd3, 32'h500, 3, BURST_INCR, 0);
        chk("rst_mem_kept", rb[3], 32'hA000_0003);

        // out-of-window read: DECERR or alias to word 0
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        axi_write(4'd8, 32'h0, 0, BURST_INCR, 0, 1'b0, 1'b0);
        axi_read(4'd8, 32'h0001_0000, 0, BURST_INCR, 0);
`ifdef AXI_SLV_DECERR_EN
        chk("decerr_rdata", rb[0], 32'd0);
        chk("decerr_rresp", 32'(first_rresp), 32'd3);
`else
        chk("alias_rdata", rb[0], 32'hCAFEF00D);
        chk("alias_rresp", 32'(first_rresp), 32'd0);
`endif

        // random traffic over a preloaded region
        for (int i = 0; i < 80; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        axi_write(4'd0, 32'h1000, 79, BURST_INCR, 0, 1'b0, 1'b0);
        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(0, 7);
            br  = 2'($urandom_range(0, 3));
            a   = 32'h1000 + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | 32'h0001_0000;
            for (int b = 0; b <= len; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom_range(0, 15)); end
            axi_write(4'($urandom_range(0, 15)), a, len, br, $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 3) == 0) a = a ^ 32'h0001_0000;
            axi_read(4'($urandom_range(0, 15)), a, len, br, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
